mips_run_ctrl: RTL and testbench



---
 rtl/mips_tb_pkg.sv | 15 +
 rtl/mips_run_ctrl_if.sv | 18 +
 rtl/trace_fifo.sv | 42 ++++
 rtl/mips_run_ctrl.sv | 77 +++++++
 tb/tb_mips_run_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_tb_pkg.sv
// mips_tb_pkg: shared state type, trace entry layout and default sizing for the run controller
package mips_tb_pkg;
    typedef enum logic [1:0] {HOLD, RUN, DONE, TIMEOUT} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_t;
    localparam int TRACE_W = 69;
    localparam int DEF_RESET_CYCLES = 5;
    localparam int DEF_MAX_CYCLES = 10000;
    localparam int DEF_HALT_REPEAT = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if: commit/writeback inputs, run status and trace-consumer handshake
interface mips_run_ctrl_if #(parameter int CNT_W = 32);
    logic restart, commit_valid, wb_we, trace_ready;
    logic core_reset, running, done, timeout, trace_valid, overflow;
    logic [31:0] commit_pc, wb_data, wb_pc, trace_pc, trace_data;
    logic [4:0] wb_addr, trace_addr;
    logic [CNT_W-1:0] cycle_count;
    modport master(
        output restart, commit_valid, commit_pc, wb_we, wb_addr, wb_data, wb_pc, trace_ready,
        input  core_reset, running, done, timeout, cycle_count, trace_valid, trace_pc, trace_addr,
               trace_data, overflow
    );
    modport slave(
        input  restart, commit_valid, commit_pc, wb_we, wb_addr, wb_data, wb_pc, trace_ready,
        output core_reset, running, done, timeout, cycle_count, trace_valid, trace_pc, trace_addr,
               trace_data, overflow
    );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with wrap-bit pointers; a push into a full FIFO without a pop is dropped and flagged
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 69
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic         overflow,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [W-1:0] mem [DEPTH];
    logic full, take, drain;
    assign valid = wp != rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign drain = pop && valid;
    // a pop on the same edge frees the slot the push lands in
    assign take = push && (!full || drain);
    assign dout = valid ? mem[rp[AW-1:0]] : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
            overflow <= 1'b0;
        end else begin
            if (take) wp <= wp + 1'b1;
            if (drain) rp <= rp + 1'b1;
            if (push && !take) overflow <= 1'b1;
        end
    always_ff @(posedge clk)
        if (take && !clr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences core reset, counts run cycles, detects halt/timeout and traces GRF writebacks
module mips_run_ctrl
    import mips_tb_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic reset,
    mips_run_ctrl_if.slave bus
);
    localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    localparam int RW = $clog2(HALT_REPEAT + 1);
    state_t state, next;
    logic [HW-1:0] hold;
    logic [RW-1:0] rep;
    logic [31:0] last_pc;
    logic [CNT_W-1:0] cnt;
    logic same, halt, push;
    trace_t entry, head;
    // rep == 0 means no PC recorded yet, so a first commit never counts as a repeat
    assign same = rep != '0 && bus.commit_pc == last_pc;
    assign halt = state == RUN && bus.commit_valid && same && rep == RW'(HALT_REPEAT - 1);
    assign push = state == RUN && bus.wb_we && bus.wb_addr != 5'd0;
    assign entry = '{pc: bus.wb_pc, addr: bus.wb_addr, data: bus.wb_data};
    always_comb begin
        next = state;
        bus.core_reset = state == HOLD;
        bus.running = state == RUN;
        bus.done = state == DONE;
        bus.timeout = state == TIMEOUT;
        bus.cycle_count = cnt;
        bus.trace_pc = head.pc;
        bus.trace_addr = head.addr;
        bus.trace_data = head.data;
        if (bus.restart) next = HOLD;
        else if (state == HOLD && hold == HW'(RESET_CYCLES - 1)) next = RUN;
        else if (halt) next = DONE;
        else if (state == RUN && cnt == CNT_W'(MAX_CYCLES - 1)) next = TIMEOUT;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= HOLD;
            hold <= '0;
            rep <= '0;
            last_pc <= '0;
            cnt <= '0;
        end else begin
            state <= next;
            hold <= (state == HOLD && next == HOLD && !bus.restart) ? hold + 1'b1 : '0;
            if (bus.restart) begin
                rep <= '0;
                last_pc <= '0;
                cnt <= '0;
            end else begin
                if (state == RUN && bus.commit_valid) begin
                    rep <= same ? rep + 1'b1 : RW'(1);
                    last_pc <= bus.commit_pc;
                end
                if (state == RUN && next == RUN && !(&cnt)) cnt <= cnt + 1'b1;
            end
        end
    trace_fifo #(.DEPTH(DEPTH), .W(TRACE_W)) u_fifo (
        .clk(clk),
        .rst(reset),
        .clr(bus.restart),
        .push(push),
        .pop(bus.trace_ready),
        .din(entry),
        .valid(bus.trace_valid),
        .overflow(bus.overflow),
        .dout(head)
    );
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed and random stimulus checked every cycle against a queue-based run/trace model
`timescale 1ns/1ps
module tb_mips_run_ctrl;
    localparam int RC = 5, MAXC = 20, HR = 4, DEPTH = 8;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    mips_run_ctrl_if #(.CNT_W(32)) bus();
    mips_run_ctrl #(
        .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR), .DEPTH(DEPTH), .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int compared = 0, mismatched = 0;
    int m_hold, m_cnt, m_rep;
    bit m_run, m_done, m_to, m_ovf;
    logic [31:0] m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = RC;
        m_cnt = 0;
        m_rep = 0;
        m_last = '0;
        m_run = 0;
        m_done = 0;
        m_to = 0;
        m_ovf = 0;
        q.delete();
    endtask

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit pop, push, acc;
        ent_t e;
        if (bus.restart) begin
            model_reset();
            return;
        end
        pop = q.size() != 0 && bus.trace_ready;
        push = m_run && bus.wb_we && bus.wb_addr != 5'd0;
        acc = push && (q.size() < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.pc = bus.wb_pc;
            e.addr = bus.wb_addr;
            e.data = bus.wb_data;
            q.push_back(e);
        end else if (push) m_ovf = 1;
        if (m_hold > 0) begin
            m_hold--;
            m_run = m_hold == 0;
        end else if (m_run) begin
            if (bus.commit_valid) begin
                if (m_rep > 0 && bus.commit_pc == m_last) m_rep++;
                else begin
                    m_rep = 1;
                    m_last = bus.commit_pc;
                end
            end
            if (m_rep == HR) begin
                m_run = 0;
                m_done = 1;
            end else if (m_cnt == MAXC - 1) begin
                m_run = 0;
                m_to = 1;
            end else m_cnt++;
        end
    endtask

    task automatic check_all();
        logic [31:0] hp, hd;
        logic [4:0] ha;
        hp = '0;
        hd = '0;
        ha = '0;
        if (q.size() != 0) begin
            hp = q[0].pc;
            ha = q[0].addr;
            hd = q[0].data;
        end
        chk("core_reset", bus.core_reset, m_hold > 0);
        chk("running", bus.running, m_run);
        chk("done", bus.done, m_done);
        chk("timeout", bus.timeout, m_to);
        chk("cycle_count", bus.cycle_count, m_cnt);
        chk("overflow", bus.overflow, m_ovf);
        chk("trace_valid", bus.trace_valid, q.size() != 0);
        chk("trace_pc", bus.trace_pc, hp);
        chk("trace_addr", bus.trace_addr, ha);
        chk("trace_data", bus.trace_data, hd);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        bus.restart = 0;
        bus.commit_valid = 0;
        bus.wb_we = 0;
        bus.trace_ready = 0;
    endtask

    task automatic restart_run();
        quiet();
        bus.restart = 1;
        cycle();
        bus.restart = 0;
        repeat (RC) cycle();
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic rdy);
        bus.wb_we = 1;
        bus.wb_addr = a;
        bus.wb_data = d;
        bus.wb_pc = 32'h3000 + 32'(a) * 4;
        bus.trace_ready = rdy;
        cycle();
    endtask

    logic [31:0] pcs [8];
    logic vld [8];

    initial begin
        quiet();
        bus.commit_pc = '0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.wb_pc = '0;
        model_reset();
        #50 check_all();
        #50 reset = 0;
        #1 check_all();
        repeat (RC) cycle();
        chk("run_after_hold", bus.running, 1'b1);
        // halt: 0x300C committed four times, one stall in between
        pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h300C, 32'h300C, 32'h300C, 32'h300C};
        vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.commit_valid = vld[i];
            bus.commit_pc = pcs[i];
            cycle();
        end
        bus.commit_valid = 0;
        chk("halt_done", bus.done, 1'b1);
        chk("halt_count", bus.cycle_count, 32'd7);
        repeat (3) cycle();
        chk("halt_frozen", bus.cycle_count, 32'd7);
        // timeout with strictly increasing PCs
        restart_run();
        for (int i = 0; i < MAXC + 2; i++) begin
            bus.commit_valid = 1;
            bus.commit_pc = 32'h5000 + 32'(i) * 4;
            cycle();
        end
        bus.commit_valid = 0;
        chk("to_flag", bus.timeout, 1'b1);
        chk("to_count", bus.cycle_count, 32'd19);
        bus.restart = 1;
        cycle();
        bus.restart = 0;
        chk("restart_core_reset", bus.core_reset, 1'b1);
        chk("restart_timeout", bus.timeout, 1'b0);
        repeat (RC) cycle();
        // trace order, $0 filtered
        wb(5'd1, 32'h11, 1'b0);
        wb(5'd0, 32'hFF, 1'b0);
        wb(5'd2, 32'h22, 1'b0);
        bus.wb_we = 0;
        cycle();
        chk("head1_addr", bus.trace_addr, 5'd1);
        chk("head1_data", bus.trace_data, 32'h11);
        bus.trace_ready = 1;
        cycle();
        chk("head2_addr", bus.trace_addr, 5'd2);
        chk("head2_data", bus.trace_data, 32'h22);
        cycle();
        chk("drained", bus.trace_valid, 1'b0);
        // fill, push+pop when full, then overflow
        restart_run();
        for (int i = 1; i <= DEPTH; i++) wb(5'(i), $urandom, 1'b0);
        chk("full_no_ovf", bus.overflow, 1'b0);
        wb(5'd20, 32'hABCD, 1'b1);
        chk("pushpop_no_ovf", bus.overflow, 1'b0);
        wb(5'd21, 32'hDEAD, 1'b0);
        chk("ovf_set", bus.overflow, 1'b1);
        quiet();
        bus.trace_ready = 1;
        repeat (DEPTH + 12) cycle();
        chk("drain_after_end", bus.trace_valid, 1'b0);
        // random programs with occasional restarts
        for (int r = 0; r < 6; r++) begin
            restart_run();
            for (int c = 0; c < 30; c++) begin
                bus.restart = ($urandom % 40) == 0;
                bus.commit_valid = $urandom % 2;
                bus.commit_pc = 32'h400 + 32'($urandom % 2) * 4;
                bus.wb_we = $urandom % 2;
                bus.wb_addr = 5'($urandom % 4);
                bus.wb_data = $urandom;
                bus.wb_pc = $urandom;
                bus.trace_ready = ($urandom % 3) == 0;
                cycle();
            end
        end
        // asynchronous reset with a half-full FIFO
        restart_run();
        for (int i = 1; i <= DEPTH / 2; i++) wb(5'(i), $urandom, 1'b0);
        quiet();
        #2 reset = 1;
        #1 model_reset();
        check_all();
        chk("async_core_reset", bus.core_reset, 1'b1);
        chk("async_valid", bus.trace_valid, 1'b0);
        @(negedge clk);
        check_all();
        reset = 0;
        repeat (RC + 3) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
